// File: rtl/kbd_rx_ctrl.sv
// Keyboard receive sequencer: synchronizes the keyboard clock/data, frames start + 8 data bits,
// strobes them into the 74LS322 shift register and raises irq until the host acknowledges.
//   state | meaning
//   IDLE  | waiting for a start bit (sample 1 on a keyboard clock fall)
//   SHIFT | shifting 8 data bits into the ls322, inter-edge timeout running
//   FULL  | scan code ready, irq and keyboard clock inhibit asserted
//   ABORT | one-cycle ls322 clear after timeout or disable
module kbd_rx_ctrl #(
  parameter int unsigned TIMEOUT = 2000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic kbd_clk,
  input  logic kbd_data,
  input  logic enable,
  input  logic ack,
  input  logic rd_n,
  output logic sr_g_n,
  output logic sr_sp_n,
  output logic sr_se_n,
  output logic sr_d0,
  output logic sr_d1,
  output logic sr_ds,
  output logic sr_clr_n,
  output logic sr_oe_n,
  output logic irq,
  output logic kbd_clk_hold,
  output logic frame_err
);

  localparam logic [15:0] TIMEOUT_LD = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SHIFT, FULL, ABORT} state_t;

  state_t      state;
  logic [1:0]  clk_sync;
  logic [1:0]  data_sync;
  logic        clk_old;
  logic        fall;
  logic        sample;
  logic [2:0]  bit_cnt;
  logic [15:0] timer;

  // ls322 is used in serial-in mode only, with ds as the serial source
  assign sr_sp_n = 1'b1;
  assign sr_se_n = 1'b1;
  assign sr_d0   = 1'b0;
  assign sr_d1   = 1'b1;

  assign fall   = clk_old & ~clk_sync[1];
  assign sample = data_sync[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= 2'b00;
      data_sync <= 2'b00;
      clk_old   <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], kbd_clk};
      data_sync <= {data_sync[0], kbd_data};
      clk_old   <= clk_sync[1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      timer        <= 16'd0;
      sr_g_n       <= 1'b1;
      sr_ds        <= 1'b0;
      sr_clr_n     <= 1'b0;
      sr_oe_n      <= 1'b1;
      irq          <= 1'b0;
      kbd_clk_hold <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sr_oe_n   <= rd_n;
      sr_g_n    <= 1'b1;
      sr_clr_n  <= 1'b1;
      frame_err <= 1'b0;
      if (!enable) begin
        state        <= (state == IDLE || state == ABORT) ? IDLE : ABORT;
        sr_clr_n     <= 1'b0;
        kbd_clk_hold <= 1'b1;
        irq          <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            irq          <= 1'b0;
            kbd_clk_hold <= 1'b0;
            if (fall && sample) begin
              state   <= SHIFT;
              bit_cnt <= 3'd0;
              timer   <= TIMEOUT_LD;
            end
          end
          SHIFT: begin
            // an edge takes priority over a timeout landing in the same cycle
            if (fall) begin
              sr_ds   <= sample;
              sr_g_n  <= 1'b0;
              bit_cnt <= bit_cnt + 3'd1;
              timer   <= TIMEOUT_LD;
              if (bit_cnt == 3'd7) state <= FULL;
            end else if (timer == 16'd0) begin
              state     <= ABORT;
              frame_err <= 1'b1;
              sr_clr_n  <= 1'b0;
            end else begin
              timer <= timer - 16'd1;
            end
          end
          FULL: begin
            if (ack) begin
              state        <= IDLE;
              sr_clr_n     <= 1'b0;
              irq          <= 1'b0;
              kbd_clk_hold <= 1'b0;
            end else begin
              irq          <= 1'b1;
              kbd_clk_hold <= 1'b1;
            end
          end
          default: begin
            state        <= IDLE;
            irq          <= 1'b0;
            kbd_clk_hold <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kbd_rx_ctrl.sv
// Directed bench for kbd_rx_ctrl with a behavioural 74LS322 (serial mode) on its outputs.
module tb_kbd_rx_ctrl;
  localparam int TO = 2000;

  logic clock = 1'b0, reset_n = 1'b0;
  logic kbd_clk = 1'b1, kbd_data = 1'b1, enable = 1'b1, ack = 1'b0, rd_n = 1'b1;
  logic sr_g_n, sr_sp_n, sr_se_n, sr_d0, sr_d1, sr_ds, sr_clr_n, sr_oe_n;
  logic irq, kbd_clk_hold, frame_err;

  int tests = 0, fails = 0;
  int g_count = 0, clr_count = 0, ferr_count = 0, g_double = 0;
  int g0, c0, f0;
  logic       g_prev = 1'b1;
  logic [7:0] ds_seq = 8'h00;
  logic [7:0] q_model;
  wire  [7:0] bus = sr_oe_n ? 8'hzz : q_model;

  kbd_rx_ctrl #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .kbd_clk(kbd_clk), .kbd_data(kbd_data),
    .enable(enable), .ack(ack), .rd_n(rd_n), .sr_g_n(sr_g_n), .sr_sp_n(sr_sp_n),
    .sr_se_n(sr_se_n), .sr_d0(sr_d0), .sr_d1(sr_d1), .sr_ds(sr_ds), .sr_clr_n(sr_clr_n),
    .sr_oe_n(sr_oe_n), .irq(irq), .kbd_clk_hold(kbd_clk_hold), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  // ls322 in serial mode: ds enters q[7], shifts toward q[0]; async clear
  always @(posedge clock or negedge sr_clr_n)
    if (!sr_clr_n) q_model <= 8'h00;
    else if (!sr_g_n) q_model <= {sr_ds, q_model[7:1]};

  always @(negedge clock)
    if (reset_n) begin
      if (!sr_g_n) begin
        g_count++;
        ds_seq = {ds_seq[6:0], sr_ds};
        if (!g_prev) g_double++;
      end
      g_prev = sr_g_n;
      if (!sr_clr_n) clr_count++;
      if (frame_err) ferr_count++;
    end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    kbd_data = b;
    wait_cyc(6);
    kbd_clk = 1'b0;
    wait_cyc(6);
    kbd_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_bit(1'b1);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    wait_cyc(8);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    wait_cyc(1);
    ack = 1'b0;
    wait_cyc(3);
  endtask

  initial begin
    wait_cyc(3);
    check("rst_clr_n", 16'(sr_clr_n), 16'h0);
    check("rst_g_n", 16'(sr_g_n), 16'h1);
    check("rst_ds", 16'(sr_ds), 16'h0);
    check("rst_oe_n", 16'(sr_oe_n), 16'h1);
    check("rst_irq_hold_ferr", 16'({irq, kbd_clk_hold, frame_err}), 16'h0);
    check("rst_consts", 16'({sr_sp_n, sr_se_n, sr_d0, sr_d1}), 16'hD);
    reset_n = 1'b1;
    wait_cyc(2);
    check("post_rst_clr_n", 16'(sr_clr_n), 16'h1);

    // frame 0xA5
    g0 = g_count;
    send_frame(8'hA5);
    check("a5_pulses", 16'(g_count - g0), 16'd8);
    check("a5_ds_seq", 16'(ds_seq), 16'hA5);
    check("a5_irq", 16'(irq), 16'h1);
    check("a5_hold", 16'(kbd_clk_hold), 16'h1);
    rd_n = 1'b0;
    wait_cyc(2);
    check("a5_oe_n", 16'(sr_oe_n), 16'h0);
    check("a5_bus", 16'(bus), 16'hA5);
    rd_n = 1'b1;

    // edges during FULL are ignored
    send_bit(1'b0);
    send_bit(1'b1);
    wait_cyc(4);
    check("full_edges_pulses", 16'(g_count - g0), 16'd8);
    check("full_edges_q", 16'(q_model), 16'hA5);
    check("full_edges_irq", 16'(irq), 16'h1);

    c0 = clr_count;
    pulse_ack();
    check("ack_clr_pulse", 16'(clr_count - c0), 16'd1);
    check("ack_q", 16'(q_model), 16'h00);
    check("ack_irq", 16'(irq), 16'h0);
    check("ack_hold", 16'(kbd_clk_hold), 16'h0);

    g0 = g_count;
    send_frame(8'h3C);
    check("3c_pulses", 16'(g_count - g0), 16'd8);
    check("3c_q", 16'(q_model), 16'h3C);
    check("3c_irq", 16'(irq), 16'h1);
    pulse_ack();

    // start bit 0 never opens a frame
    g0 = g_count;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    wait_cyc(10);
    check("start0_pulses", 16'(g_count - g0), 16'd0);
    check("start0_irq", 16'(irq), 16'h0);

    // 4 data bits then silence -> timeout abort
    g0 = g_count; c0 = clr_count; f0 = ferr_count;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    check("to_partial_pulses", 16'(g_count - g0), 16'd4);
    check("to_partial_q", 16'(q_model), 16'hD0);
    wait_cyc(TO + 5);
    check("to_ferr", 16'(ferr_count - f0), 16'd1);
    check("to_clr", 16'(clr_count - c0), 16'd1);
    check("to_q", 16'(q_model), 16'h00);
    check("to_irq", 16'(irq), 16'h0);
    g0 = g_count;
    send_frame(8'hFF);
    check("ff_pulses", 16'(g_count - g0), 16'd8);
    check("ff_q", 16'(q_model), 16'hFF);
    pulse_ack();

    // disable mid-frame
    f0 = ferr_count;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    enable = 1'b0;
    wait_cyc(3);
    check("dis_clr_n", 16'(sr_clr_n), 16'h0);
    check("dis_hold", 16'(kbd_clk_hold), 16'h1);
    check("dis_q", 16'(q_model), 16'h00);
    send_bit(1'b1);
    wait_cyc(20);
    check("dis_clr_n_held", 16'(sr_clr_n), 16'h0);
    check("dis_irq", 16'(irq), 16'h0);
    check("dis_no_ferr", 16'(ferr_count - f0), 16'd0);
    enable = 1'b1;
    wait_cyc(3);
    check("en_clr_n", 16'(sr_clr_n), 16'h1);
    check("en_hold", 16'(kbd_clk_hold), 16'h0);
    send_frame(8'h01);
    check("01_q", 16'(q_model), 16'h01);
    check("01_ds_seq", 16'(ds_seq), 16'h80);
    check("01_irq", 16'(irq), 16'h1);
    pulse_ack();

    // ack while IDLE does nothing
    c0 = clr_count;
    pulse_ack();
    check("idle_ack_clr", 16'(clr_count - c0), 16'd0);
    check("idle_ack_irq", 16'(irq), 16'h0);

    // async reset mid-frame
    rd_n = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    check("mid_q", 16'(q_model), 16'hC0);
    check("mid_ds", 16'(sr_ds), 16'h1);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("arst_g_n", 16'(sr_g_n), 16'h1);
    check("arst_ds", 16'(sr_ds), 16'h0);
    check("arst_clr_n", 16'(sr_clr_n), 16'h0);
    check("arst_oe_n", 16'(sr_oe_n), 16'h1);
    check("arst_q", 16'(q_model), 16'h00);
    wait_cyc(2);
    reset_n = 1'b1;
    rd_n = 1'b1;
    wait_cyc(3);
    check("arst_rel_clr_n", 16'(sr_clr_n), 16'h1);
    send_frame(8'h96);
    check("96_q", 16'(q_model), 16'h96);
    check("96_irq", 16'(irq), 16'h1);
    check("g_single_cycle", 16'(g_double), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/kbd_rx_ctrl.md
# kbd_rx_ctrl

Receive sequencer for the keyboard port's 74LS322 8-bit shift register (`ls322`). It synchronizes the external keyboard clock and data lines and frames start and data bits. It issues one-cycle shift strobes into the `ls322`, then raises `irq` and holds the keyboard clock low until the host acknowledges. The block sits between the keyboard connector and the `ls322`. The host reads the received scan code straight off the `ls322` bus while this block drives `sr_oe_n`.

## Interface
- `TIMEOUT`, default 2000: `clock` cycles allowed between keyboard clock falling edges within a frame before abort.
- `clock` in 1: system clock; all state changes on the rising edge.
- `reset_n` in 1: reset is asynchronous and active-low.
- `kbd_clk` in 1: raw keyboard clock, asynchronous.
- `kbd_data` in 1: raw keyboard data, asynchronous.
- `enable` in 1: host port enable; low holds the block idle and keeps the `ls322` cleared.
- `ack` in 1: host acknowledge pulse; honoured only in FULL.
- `rd_n` in 1: host read strobe, active-low.
- `sr_g_n` out 1: `ls322` `g_n`; low for exactly one cycle per shift.
- `sr_sp_n` out 1: `ls322` `sp_n`; constant 1 (serial mode only).
- `sr_se_n` out 1: `ls322` `se_n`; constant 1.
- `sr_d0`, `sr_d1` out 1 each: `ls322` serial select; constant 0 and 1 (`ds` is the serial source).
- `sr_ds` out 1: serial data into `ls322`.
- `sr_clr_n` out 1: `ls322` `clr_n`.
- `sr_oe_n` out 1: `ls322` `oe_n`; equals `rd_n`, registered.
- `irq` out 1: scan code ready (IRQ1).
- `kbd_clk_hold` out 1: high pulls the keyboard clock low (inhibit).
- `frame_err` out 1: one-cycle pulse on timeout abort.

## Operation
- Input conditioning:
  - `kbd_clk` and `kbd_data` each pass through a 2-flop synchronizer.
  - A falling edge is old-synced=1 and new-synced=0.
  - Data is sampled from the synced `kbd_data` in the edge cycle.
- Frame format: start bit (must be 1), then 8 data bits LSB first. `ds` enters at q[7] and shifts toward q[0], so after 8 shifts the LSB sits at q[0].
- States:
  - IDLE: wait for an edge.
    - Edge with sample 1: go to SHIFT, bit count = 0, no shift.
    - Edge with sample 0: ignored, stay in IDLE.
  - SHIFT: each edge drives `sr_ds` = sample and `sr_g_n` = 0 for the following cycle, and increments the 3-bit count.
    - After the 8th shift (count wraps 7→0), go to FULL.
  - FULL: `irq`=1 and `kbd_clk_hold`=1; edges are ignored.
    - `ack` → `sr_clr_n`=0 for one cycle, then IDLE.
    - `irq` and `kbd_clk_hold` drop in that same cycle.
  - ABORT, one cycle: `sr_clr_n`=0, then IDLE.
- Timeout:
  - A 16-bit counter runs in SHIFT and resets on every edge.
  - When the counter reaches `TIMEOUT`, go to ABORT with `frame_err`=1 for that cycle.
- `enable`=0:
  - From any state, go to ABORT without `frame_err`, then hold IDLE.
  - `sr_clr_n`=0 continuously while `enable`=0.
  - `kbd_clk_hold`=1 while `enable`=0; `irq`=0.
- Host read: the `ls322` contents are valid on the bus whenever `sr_oe_n`=0. Reading does not change state.

## Timing
- Reset values:
  - `sr_g_n`=1, `sr_sp_n`=1, `sr_se_n`=1, `sr_d0`=0, `sr_d1`=1, `sr_ds`=0.
  - `sr_clr_n`=0 while `reset_n`=0, then 1.
  - `sr_oe_n`=1, `irq`=0, `kbd_clk_hold`=0, `frame_err`=0, state IDLE, counters 0.
- Latency:
  - Raw `kbd_clk` fall to the edge-detect cycle is 2–3 clocks.
  - `sr_g_n` low occurs in the cycle after detection, with `sr_ds` stable in that same cycle.
  - The `ls322` captures on the rising edge that ends the `sr_g_n` low cycle.
- `irq` rises in the cycle after the 8th `sr_g_n` pulse, so `ls322` q is final when `irq` is seen.
- Simultaneous events:
  - `ack` outside FULL is ignored.
  - `ack` and `enable`=0 together: `enable` wins (ABORT).
  - An edge and a timeout in the same cycle: the edge wins.
- Reset mid-frame: the asynchronous reset forces all outputs to their reset values immediately; the partial frame is discarded.
- The minimum keyboard clock low/high is 3 clocks each; faster edges are undefined.

## Test plan
- Reset, then frame start=1 with data 0xA5 (bits 1,0,1,0,0,1,0,1) → exactly 8 `sr_g_n` pulses, `sr_ds` sequence matches, `irq`=1, `kbd_clk_hold`=1, `ls322` q=10100101 on `rd_n`=0.
- In FULL, pulse `ack` → one `sr_clr_n`=0 cycle, q=00000000, `irq`=0, `kbd_clk_hold`=0, next frame 0x3C received correctly.
- Start bit 0 followed by edges → no `sr_g_n` pulse, `irq` stays 0.
- 4 data bits, then no edges for `TIMEOUT`+5 clocks → one `frame_err` pulse, `sr_clr_n` pulse, q=00000000; next full frame 0xFF gives q=11111111.
- `enable`=0 mid-frame → `sr_clr_n` held 0, `kbd_clk_hold`=1, no `irq`; `enable`=1 then frame 0x01 → q=00000001.
- Keyboard edges during FULL and `ack` while IDLE → q unchanged and no state change; `reset_n` low mid-frame → all outputs take reset values asynchronously.
